instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one outstanding fetch, holds the instruction until the decoder takes it; 1-cycle capture, 1 instr per 2 cycles.
// Define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirect targets; otherwise targets are word-aligned by dropping bits [1:0].
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_register,
    output logic        instruction_valid,
    output logic [31:0] pc,
    input  logic        decode_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQUEST, HOLD, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
    logic        target_aligned;
    assign target_aligned = (redirect_target[1:0] == 2'b00);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: state_d = REQUEST;
            REQUEST, HOLD: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    pc_d = redirect_target;
                    if (target_aligned) begin
                        state_d = REQUEST;
                    end else begin
                        state_d = FAULT;
                        mis_d   = 1'b1;
                    end
`else
                    pc_d    = redirect_target & 32'hFFFF_FFFC;
                    state_d = REQUEST;
`endif
                end else if (state_q == REQUEST && imem_ready) begin
                    ir_d    = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (state_q == HOLD && decode_ready) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    state_d = REQUEST;
                end
            end
            FAULT: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                // Only an aligned redirect restarts fetching; misaligned ones just move pc.
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (target_aligned) begin
                        mis_d   = 1'b0;
                        state_d = REQUEST;
                    end
                end
`else
                state_d = REQUEST;
`endif
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQUEST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            ir_q    <= NOP;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            req_q   <= req_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign imem_req             = req_q;
    assign imem_addr            = pc_q;
    assign pc                   = pc_q;
    assign instruction_register = ir_q;
    assign instruction_valid    = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misaligned     = mis_q;
`else
    assign fetch_misaligned     = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic against a behavioural model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction_register;
    logic        instruction_valid;
    logic [31:0] pc;
    logic        decode_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        fetch_misaligned;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: what has been fetched, where the stream is, and whether it is halted.
    logic [31:0] m_pc = RV;
    logic [31:0] m_ir = NOP;
    bit          m_valid = 1'b0;
    bit          m_started = 1'b0;
    bit          m_mis = 1'b0;

    instruction_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction_register(instruction_register), .instruction_valid(instruction_valid),
        .pc(pc), .decode_ready(decode_ready), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic bit exp_req();
        return m_started && !m_valid && !m_mis;
    endfunction

    task automatic drive(input bit rst, input bit rdy, input bit dr, input bit rv,
                         input logic [31:0] tgt, input logic [31:0] data);
        reset = rst; imem_ready = rdy; decode_ready = dr;
        redirect_valid = rv; redirect_target = tgt; imem_rdata = data;
    endtask

    // One clock edge: model consumes the inputs held across the edge, outputs settle 1ns later.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_pc = RV; m_ir = NOP; m_valid = 0; m_started = 0; m_mis = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_mis) begin
            if (redirect_valid) begin
                m_pc = redirect_target;
                if (redirect_target[1:0] == 2'b00) m_mis = 0;
            end
        end else if (redirect_valid) begin
            m_valid = 0;
            if (TRAP && redirect_target[1:0] != 2'b00) begin
                m_pc = redirect_target; m_mis = 1;
            end else begin
                m_pc = {redirect_target[31:2], 2'b00};
            end
        end else if (m_valid) begin
            if (decode_ready) begin m_pc = m_pc + 32'd4; m_valid = 0; end
        end else if (imem_ready) begin
            m_ir = imem_rdata; m_valid = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 32'h0000_0444, 32'hDEAD_BEEF);
        step(); step();
        vectors++;
        if ({imem_req, imem_addr, pc, instruction_register, instruction_valid, fetch_misaligned}
            !== {1'b0, RV, RV, NOP, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: req=%b addr=%h ir=%h vld=%b mis=%b, want 0 %h %h 0 0",
                     imem_req, imem_addr, instruction_register, instruction_valid, fetch_misaligned, RV, NOP);
        end
    endtask

    task automatic test_reset_release();
        drive(0, 1, 0, 0, 32'h0, 32'hA000_0001);
        step();
        vectors++;
        if ({imem_req, imem_addr, instruction_valid} !== {1'b1, 32'h0000_0100, 1'b0}) begin
            miscompares++;
            $display("FAIL release_req: req=%b addr=%h vld=%b, want 1 00000100 0", imem_req, imem_addr, instruction_valid);
        end
        step();
        vectors++;
        if ({instruction_valid, instruction_register, imem_req} !== {1'b1, 32'hA000_0001, 1'b0}) begin
            miscompares++;
            $display("FAIL release_capture: vld=%b ir=%h req=%b, want 1 a0000001 0",
                     instruction_valid, instruction_register, imem_req);
        end
    endtask

    task automatic test_decode_stall();
        drive(0, 1, 0, 0, 32'h0, 32'h5555_5555);
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({instruction_register, pc, instruction_valid, imem_req} !== {32'hA000_0001, 32'h100, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL stall[%0d]: ir=%h pc=%h vld=%b req=%b, want a0000001 00000100 1 0",
                         i, instruction_register, pc, instruction_valid, imem_req);
            end
        end
        decode_ready = 1;
        step();
        vectors++;
        if ({pc, instruction_valid, imem_req, instruction_register} !== {32'h104, 1'b0, 1'b1, 32'hA000_0001}) begin
            miscompares++;
            $display("FAIL stall_release: pc=%h vld=%b req=%b ir=%h, want 00000104 0 1 a0000001",
                     pc, instruction_valid, imem_req, instruction_register);
        end
    endtask

    task automatic test_wait_states();
        drive(0, 0, 1, 0, 32'h0, 32'hB000_0002);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({imem_req, imem_addr, instruction_valid} !== {1'b1, 32'h104, 1'b0}) begin
                miscompares++;
                $display("FAIL wait[%0d]: req=%b addr=%h vld=%b, want 1 00000104 0", i, imem_req, imem_addr, instruction_valid);
            end
        end
        imem_ready = 1; decode_ready = 0;
        step();
        vectors++;
        if ({instruction_valid, instruction_register} !== {1'b1, 32'hB000_0002}) begin
            miscompares++;
            $display("FAIL wait_capture: vld=%b ir=%h, want 1 b0000002", instruction_valid, instruction_register);
        end
        decode_ready = 1; imem_ready = 0;
        step();
    endtask

    task automatic test_redirect_collision();
        // Redirect during REQUEST while memory answers: data is dropped.
        drive(0, 1, 0, 1, 32'h0000_0200, 32'hC000_0003);
        step();
        vectors++;
        if ({instruction_valid, instruction_register, imem_addr, imem_req} !== {1'b0, 32'hB000_0002, 32'h200, 1'b1}) begin
            miscompares++;
            $display("FAIL redirect_req: vld=%b ir=%h addr=%h req=%b, want 0 b0000002 00000200 1",
                     instruction_valid, instruction_register, imem_addr, imem_req);
        end
        drive(0, 1, 0, 0, 32'h0, 32'hD000_0004);
        step();
        // Redirect during HOLD, coincident with imem_ready and decode_ready.
        drive(0, 1, 1, 1, 32'h0000_0200, 32'hE000_0005);
        step();
        vectors++;
        if ({instruction_valid, instruction_register, imem_addr, imem_req} !== {1'b0, 32'hD000_0004, 32'h200, 1'b1}) begin
            miscompares++;
            $display("FAIL redirect_hold: vld=%b ir=%h addr=%h req=%b, want 0 d0000004 00000200 1",
                     instruction_valid, instruction_register, imem_addr, imem_req);
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
        step();
        drive(0, 1, 0, 0, 32'h0, 32'hF000_0006);
        step();
        drive(0, 0, 1, 0, 32'h0, 32'h0);
        step();
        vectors++;
        if ({imem_addr, imem_req, instruction_valid} !== {32'h0000_0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap: addr=%h req=%b vld=%b, want 00000000 1 0", imem_addr, imem_req, instruction_valid);
        end
    endtask

    task automatic test_misaligned();
        drive(0, 1, 1, 1, 32'h0000_0203, 32'h1234_5678);
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        drive(0, 1, 1, 0, 32'h0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({fetch_misaligned, imem_req, instruction_valid, pc} !== {1'b1, 1'b0, 1'b0, 32'h203}) begin
                miscompares++;
                $display("FAIL misalign_halt[%0d]: mis=%b req=%b vld=%b pc=%h, want 1 0 0 00000203",
                         i, fetch_misaligned, imem_req, instruction_valid, pc);
            end
        end
        drive(0, 0, 0, 1, 32'h0000_0300, 32'h0);
        step();
        vectors++;
        if ({fetch_misaligned, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            miscompares++;
            $display("FAIL misalign_exit: mis=%b req=%b addr=%h, want 0 1 00000300", fetch_misaligned, imem_req, imem_addr);
        end
`else
        vectors++;
        if ({fetch_misaligned, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            miscompares++;
            $display("FAIL misalign_force: mis=%b req=%b addr=%h, want 0 1 00000200", fetch_misaligned, imem_req, imem_addr);
        end
`endif
    endtask

    task automatic test_midop_reset();
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        drive(1, 1, 0, 0, 32'h0, 32'h7777_7777);
        step();
        vectors++;
        if ({imem_req, pc, instruction_register, instruction_valid, fetch_misaligned}
            !== {1'b0, RV, NOP, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midop_reset: req=%b pc=%h ir=%h vld=%b mis=%b, want 0 %h %h 0 0",
                     imem_req, pc, instruction_register, instruction_valid, fetch_misaligned, RV, NOP);
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 600; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0, tgt, $urandom);
            step();
            vectors++;
            if ({imem_req, imem_addr, pc, instruction_register, instruction_valid, fetch_misaligned}
                !== {exp_req(), m_pc, m_pc, m_ir, m_valid, m_mis}) begin
                miscompares++;
                $display("FAIL random[%0d]: req=%b addr=%h pc=%h ir=%h vld=%b mis=%b, want %b %h %h %h %b %b",
                         i, imem_req, imem_addr, pc, instruction_register, instruction_valid, fetch_misaligned,
                         exp_req(), m_pc, m_pc, m_ir, m_valid, m_mis);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_decode_stall();
        test_wait_states();
        test_redirect_collision();
        test_wrap();
        test_misaligned();
        test_midop_reset();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
